cache_rand_repl: RTL and testbench



---
 rtl/randrepl_pkg.sv | 42 ++++
 rtl/cache_rand_repl_lfsr_step.sv | 25 ++
 rtl/cache_rand_repl.sv | 155 +++++++++++++++
 tb/tb_cache_rand_repl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/randrepl_pkg.sv
// -----------------------------------------------------------------------------
// randrepl_pkg
// Shared definitions for the random-replacement victim selector:
//   - lfsr_taps(width)  : Fibonacci tap mask (bit t set = curr[t] feeds the
//                         XOR into the MSB) for LFSR widths 3..16.
//   - RANDREPL_SEED_LSB : reset seed pattern (bit1 = 1, all others 0).
//   - randrepl_state_t  : allocation FSM states.
// Optional build macro used by the importing design: RANDREPL_SEED_EN.
// -----------------------------------------------------------------------------
package randrepl_pkg;

  localparam logic [1:0] RANDREPL_SEED_LSB = 2'b10;

  typedef enum logic {
    RR_IDLE = 1'b0,
    RR_HOLD = 1'b1
  } randrepl_state_t;

  // Tap masks are right-aligned: the caller keeps bits [width-1:0].
  // Widths 10..16 use primitive polynomials, so the sequence has period
  // 2^width - 1 and never visits zero.
  function automatic logic [15:0] lfsr_taps(input int width);
    case (width)
      3:       return 16'h0005;  // {2,0}
      4:       return 16'h0009;  // {3,0}
      5:       return 16'h001B;  // {4,3,1,0}
      6:       return 16'h0036;  // {5,4,2,1}
      7:       return 16'h0069;  // {6,5,3,0}
      8:       return 16'h00A6;  // {7,5,2,1}
      9:       return 16'h017C;  // {8,6,5,4,3,2}
      10:      return 16'h0081;  // {7,0}
      11:      return 16'h0201;  // {9,0}
      12:      return 16'h0053;  // {6,4,1,0}
      13:      return 16'h001B;  // {4,3,1,0}
      14:      return 16'h002B;  // {5,3,1,0}
      15:      return 16'h4001;  // {14,0}
      16:      return 16'hA011;  // {15,13,4,0}
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/cache_rand_repl_lfsr_step.sv
// -----------------------------------------------------------------------------
// lfsr_step
// Combinational next-state function of a right-shifting Fibonacci LFSR.
// Reusable by any LFSR user; taps come from randrepl_pkg::lfsr_taps.
// Ports:
//   curr : current LFSR value (WIDTH bits)
//   next : value after one shift (WIDTH bits)
// -----------------------------------------------------------------------------
module lfsr_step
  import randrepl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] curr,
  output logic [WIDTH-1:0] next
);

  localparam logic [15:0]      TAPS_FULL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

  always_comb begin
    next = {^(curr & TAPS), curr[WIDTH-1:1]};
  end

endmodule

// File: rtl/cache_rand_repl.sv
// -----------------------------------------------------------------------------
// cache_rand_repl
// Random-replacement victim selector for a set-associative cache. Invalid
// ways win over the random choice; the chosen victim is latched on an
// accepted AllocReq and held until the fill completes or is flushed. The
// LFSR advances only when a fill completes.
//
// Ports:
//   clk          : clock
//   reset        : synchronous, active-high reset
//   FlushStage   : pipeline flush, aborts a pending allocation
//   AllocReq     : miss needs a victim (sampled in IDLE)
//   FillDone     : line write completed (sampled in HOLD)
//   ValidWay     : valid bits of the addressed set (NUMWAYS)
//   SeedWrite    : (RANDREPL_SEED_EN only) load SeedData into the LFSR
//   SeedData     : (RANDREPL_SEED_EN only) seed value, 0 maps to reset seed
//   VictimWay    : one-hot victim, zero when VictimValid = 0
//   VictimValid  : victim held and valid
//   LFSRState    : current LFSR value (debug / coverage)
//
// Build macro: RANDREPL_SEED_EN adds the seed-load ports.
// -----------------------------------------------------------------------------
module cache_rand_repl
  import randrepl_pkg::*;
#(
  parameter int NUMWAYS = 4,
  parameter int WIDTH   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               FlushStage,
  input  logic               AllocReq,
  input  logic               FillDone,
  input  logic [NUMWAYS-1:0] ValidWay,
`ifdef RANDREPL_SEED_EN
  input  logic               SeedWrite,
  input  logic [WIDTH-1:0]   SeedData,
`endif
  output logic [NUMWAYS-1:0] VictimWay,
  output logic               VictimValid,
  output logic [WIDTH-1:0]   LFSRState
);

  localparam int               LOGW        = $clog2(NUMWAYS);
  localparam logic [LOGW:0]    NUMWAYS_EXT = (LOGW + 1)'(NUMWAYS);
  localparam logic [WIDTH-1:0] RESET_SEED  = WIDTH'(RANDREPL_SEED_LSB);

  randrepl_state_t    state_q, state_d;
  logic [WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [NUMWAYS-1:0] victim_way_q, victim_way_d;

  logic [WIDTH-1:0]   lfsr_next_raw;
  logic [WIDTH-1:0]   lfsr_stepped;
  logic [LOGW:0]      r_ext;
  logic [LOGW-1:0]    rand_idx;
  logic [NUMWAYS-1:0] rand_onehot;
  logic [NUMWAYS-1:0] inv_onehot;
  logic [NUMWAYS-1:0] victim_sel;
  logic               seed_load;
  logic [WIDTH-1:0]   seed_value;

  lfsr_step #(
    .WIDTH (WIDTH)
  ) u_lfsr_step (
    .curr (lfsr_q),
    .next (lfsr_next_raw)
  );

  // Victim selection: invalid-way priority encoder plus random index.
  always_comb begin
    // Some small-width tap sets are not primitive and could shift into zero;
    // falling back to the reset seed keeps the LFSR out of the lockup state.
    lfsr_stepped = (lfsr_next_raw == '0) ? RESET_SEED : lfsr_next_raw;

    // Out-of-range random values fold back with a single subtraction; for a
    // power-of-2 way count the compare is never true and idx = r.
    r_ext    = {1'b0, lfsr_q[LOGW-1:0]};
    rand_idx = (r_ext >= NUMWAYS_EXT) ? LOGW'(r_ext - NUMWAYS_EXT)
                                      : lfsr_q[LOGW-1:0];
    rand_onehot = NUMWAYS'(1) << rand_idx;

    // ~v & (v + 1) isolates the lowest clear bit of v: the lowest-index
    // invalid way. It yields zero when every way is valid.
    inv_onehot = ~ValidWay & (ValidWay + NUMWAYS'(1));
    victim_sel = (&ValidWay) ? rand_onehot : inv_onehot;
  end

  always_comb begin
`ifdef RANDREPL_SEED_EN
    seed_load  = SeedWrite;
    seed_value = (SeedData == '0) ? RESET_SEED : SeedData;
`else
    seed_load  = 1'b0;
    seed_value = RESET_SEED;
`endif
  end

  // Allocation FSM and LFSR next state.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    victim_way_d = victim_way_q;

    case (state_q)
      RR_IDLE: begin
        if (AllocReq && !FlushStage) begin
          victim_way_d = victim_sel;
          state_d      = RR_HOLD;
        end
      end
      RR_HOLD: begin
        // Flush outranks fill completion: the aborted fill must not consume
        // a random value.
        if (FlushStage) begin
          victim_way_d = '0;
          state_d      = RR_IDLE;
        end else if (FillDone) begin
          lfsr_d       = lfsr_stepped;
          victim_way_d = '0;
          state_d      = RR_IDLE;
        end
      end
      default: begin
        victim_way_d = '0;
        state_d      = RR_IDLE;
      end
    endcase

    // A seed load overrides any step in the same cycle; the FSM is untouched.
    if (seed_load) begin
      lfsr_d = seed_value;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state_q      <= RR_IDLE;
      lfsr_q       <= RESET_SEED;
      victim_way_q <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      victim_way_q <= victim_way_d;
    end
  end

  assign VictimWay   = victim_way_q;
  assign VictimValid = (state_q == RR_HOLD);
  assign LFSRState   = lfsr_q;

endmodule

// File: tb/tb_cache_rand_repl.sv
// -----------------------------------------------------------------------------
// tb_cache_rand_repl
// Directed bench for cache_rand_repl. Two instances share the control inputs:
//   dut_a : NUMWAYS=4, WIDTH=4
//   dut_b : NUMWAYS=3, WIDTH=4
// With RANDREPL_SEED_EN defined the seed-load scenario is also exercised.
// -----------------------------------------------------------------------------
module tb_cache_rand_repl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       FlushStage;
  logic       AllocReq;
  logic       FillDone;
  logic [3:0] valid_a;
  logic [2:0] valid_b;
  logic [3:0] victim_a;
  logic [2:0] victim_b;
  logic       vv_a, vv_b;
  logic [3:0] lfsr_a, lfsr_b;
`ifdef RANDREPL_SEED_EN
  logic       SeedWrite;
  logic [3:0] SeedData;
`endif

  int vectors     = 0;
  int miscompares = 0;

  cache_rand_repl #(.NUMWAYS(4), .WIDTH(4)) dut_a (
    .clk         (clk),
    .reset       (reset),
    .FlushStage  (FlushStage),
    .AllocReq    (AllocReq),
    .FillDone    (FillDone),
    .ValidWay    (valid_a),
`ifdef RANDREPL_SEED_EN
    .SeedWrite   (SeedWrite),
    .SeedData    (SeedData),
`endif
    .VictimWay   (victim_a),
    .VictimValid (vv_a),
    .LFSRState   (lfsr_a)
  );

  cache_rand_repl #(.NUMWAYS(3), .WIDTH(4)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .FlushStage  (FlushStage),
    .AllocReq    (AllocReq),
    .FillDone    (FillDone),
    .ValidWay    (valid_b),
`ifdef RANDREPL_SEED_EN
    .SeedWrite   (SeedWrite),
    .SeedData    (SeedData),
`endif
    .VictimWay   (victim_b),
    .VictimValid (vv_b),
    .LFSRState   (lfsr_b)
  );

  // Reference x^4 + x^3 + 1 LFSR, shifting right.
  function automatic logic [3:0] model_step(input logic [3:0] c);
    return {c[3] ^ c[0], c[3:1]};
  endfunction

  function automatic logic [3:0] model_victim4(input logic [3:0] l);
    case (l[1:0])
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [2:0] model_victim3(input logic [3:0] l);
    case (l[1:0])
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b001;  // 3 folds back to 0
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    AllocReq   = 1'b0;
    FillDone   = 1'b0;
    FlushStage = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (vv_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid_a: got %b want 0", vv_a);
    end
    vectors++;
    if (victim_a !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_victim_a: got %b want 0000", victim_a);
    end
    vectors++;
    if (lfsr_a !== 4'b0010) begin
      miscompares++;
      $display("FAIL reset_lfsr_a: got %b want 0010", lfsr_a);
    end
    vectors++;
    if (lfsr_b !== 4'b0010 || vv_b !== 1'b0 || victim_b !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_b: lfsr %b valid %b victim %b want 0010/0/000",
               lfsr_b, vv_b, victim_b);
    end
  endtask

  task automatic test_random_alloc();
    valid_a  = 4'b1111;
    AllocReq = 1'b1;
    tick();
    AllocReq = 1'b0;
    vectors++;
    if (vv_a !== 1'b1 || victim_a !== 4'b0100) begin
      miscompares++;
      $display("FAIL rand_alloc1: valid %b victim %b want 1/0100", vv_a, victim_a);
    end
    tick();
    vectors++;
    if (victim_a !== 4'b0100 || lfsr_a !== 4'b0010) begin
      miscompares++;
      $display("FAIL rand_hold: victim %b lfsr %b want 0100/0010", victim_a, lfsr_a);
    end
    FillDone = 1'b1;
    tick();
    FillDone = 1'b0;
    vectors++;
    if (vv_a !== 1'b0 || victim_a !== 4'b0000 || lfsr_a !== 4'b0001) begin
      miscompares++;
      $display("FAIL rand_fill1: valid %b victim %b lfsr %b want 0/0000/0001",
               vv_a, victim_a, lfsr_a);
    end
    AllocReq = 1'b1;
    tick();
    AllocReq = 1'b0;
    vectors++;
    if (victim_a !== 4'b0010) begin
      miscompares++;
      $display("FAIL rand_alloc2: victim %b want 0010", victim_a);
    end
    FillDone = 1'b1;
    tick();
    FillDone = 1'b0;
    vectors++;
    if (lfsr_a !== 4'b1000) begin
      miscompares++;
      $display("FAIL rand_fill2: lfsr %b want 1000", lfsr_a);
    end
  endtask

  // LFSR is 1000 on entry: the random path would pick way 0.
  task automatic test_invalid_priority();
    valid_a  = 4'b1011;
    AllocReq = 1'b1;
    tick();
    AllocReq = 1'b0;
    vectors++;
    if (vv_a !== 1'b1 || victim_a !== 4'b0100) begin
      miscompares++;
      $display("FAIL inv_alloc: valid %b victim %b want 1/0100", vv_a, victim_a);
    end
    valid_a  = 4'b0111;
    AllocReq = 1'b1;  // ignored in HOLD
    tick();
    valid_a  = 4'b1111;
    AllocReq = 1'b0;
    tick();
    vectors++;
    if (vv_a !== 1'b1 || victim_a !== 4'b0100) begin
      miscompares++;
      $display("FAIL inv_hold_stable: valid %b victim %b want 1/0100", vv_a, victim_a);
    end
    FillDone = 1'b1;
    tick();
    FillDone = 1'b0;
    vectors++;
    if (vv_a !== 1'b0 || lfsr_a !== 4'b1100) begin
      miscompares++;
      $display("FAIL inv_fill_step: valid %b lfsr %b want 0/1100", vv_a, lfsr_a);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    valid_a  = 4'b1111;
    AllocReq = 1'b1;
    tick();
    AllocReq = 1'b0;
    vectors++;
    if (vv_a !== 1'b1 || victim_a !== 4'b0100) begin
      miscompares++;
      $display("FAIL flush_alloc: valid %b victim %b want 1/0100", vv_a, victim_a);
    end
    FlushStage = 1'b1;
    FillDone   = 1'b1;
    tick();
    FlushStage = 1'b0;
    FillDone   = 1'b0;
    vectors++;
    if (vv_a !== 1'b0 || victim_a !== 4'b0000 || lfsr_a !== 4'b0010) begin
      miscompares++;
      $display("FAIL flush_prio: valid %b victim %b lfsr %b want 0/0000/0010",
               vv_a, victim_a, lfsr_a);
    end
    FillDone = 1'b1;  // ignored in IDLE
    tick();
    FillDone = 1'b0;
    vectors++;
    if (vv_a !== 1'b0 || lfsr_a !== 4'b0010) begin
      miscompares++;
      $display("FAIL idle_filldone: valid %b lfsr %b want 0/0010", vv_a, lfsr_a);
    end
    AllocReq   = 1'b1;
    FlushStage = 1'b1;
    tick();
    AllocReq   = 1'b0;
    FlushStage = 1'b0;
    vectors++;
    if (vv_a !== 1'b0 || victim_a !== 4'b0000) begin
      miscompares++;
      $display("FAIL idle_alloc_flush: valid %b victim %b want 0/0000", vv_a, victim_a);
    end
  endtask

  // Back-to-back allocations over one full period of the 4-bit LFSR.
  task automatic test_back_to_back();
    logic [3:0]  exp;
    logic [15:0] seen;
    logic [3:0]  hand [3];
    hand[0] = 4'b0001;
    hand[1] = 4'b1000;
    hand[2] = 4'b1100;
    apply_reset();
    valid_a = 4'b1111;
    exp     = 4'b0010;
    seen    = 16'h0004;
    for (int i = 0; i < 15; i++) begin
      AllocReq = 1'b1;
      tick();
      AllocReq = 1'b0;
      vectors++;
      if (vv_a !== 1'b1 || victim_a !== model_victim4(exp)) begin
        miscompares++;
        $display("FAIL b2b_victim[%0d]: valid %b victim %b want 1/%b",
                 i, vv_a, victim_a, model_victim4(exp));
      end
      FillDone = 1'b1;
      tick();
      FillDone = 1'b0;
      exp = model_step(exp);
      vectors++;
      if (lfsr_a !== exp || vv_a !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_lfsr[%0d]: lfsr %b valid %b want %b/0", i, lfsr_a, vv_a, exp);
      end
      if (i < 3) begin
        vectors++;
        if (lfsr_a !== hand[i]) begin
          miscompares++;
          $display("FAIL b2b_start[%0d]: lfsr %b want %b", i, lfsr_a, hand[i]);
        end
      end
      if (i < 14) begin
        vectors++;
        if (lfsr_a === 4'b0000 || seen[lfsr_a] === 1'b1) begin
          miscompares++;
          $display("FAIL b2b_distinct[%0d]: lfsr %b zero or repeated", i, lfsr_a);
        end
        seen[lfsr_a] = 1'b1;
      end
    end
    vectors++;
    if (lfsr_a !== 4'b0010) begin
      miscompares++;
      $display("FAIL b2b_period: lfsr %b want 0010", lfsr_a);
    end
  endtask

  task automatic test_nonpow2();
    logic [3:0] exp;
    apply_reset();
    valid_b = 3'b111;
    exp     = 4'b0010;
    for (int i = 0; i < 15; i++) begin
      AllocReq = 1'b1;
      tick();
      AllocReq = 1'b0;
      vectors++;
      if (vv_b !== 1'b1 || victim_b !== model_victim3(exp) || !$onehot(victim_b)) begin
        miscompares++;
        $display("FAIL np2_victim[%0d]: lfsr %b victim %b want %b",
                 i, lfsr_b, victim_b, model_victim3(exp));
      end
      if (exp[1:0] == 2'b11) begin
        vectors++;
        if (victim_b !== 3'b001) begin
          miscompares++;
          $display("FAIL np2_fold[%0d]: victim %b want 001", i, victim_b);
        end
      end
      FillDone = 1'b1;
      tick();
      FillDone = 1'b0;
      exp = model_step(exp);
    end
    valid_b  = 3'b101;
    AllocReq = 1'b1;
    tick();
    AllocReq = 1'b0;
    vectors++;
    if (vv_b !== 1'b1 || victim_b !== 3'b010) begin
      miscompares++;
      $display("FAIL np2_invalid: valid %b victim %b want 1/010", vv_b, victim_b);
    end
    valid_b = 3'b111;
    FillDone = 1'b1;
    tick();
    FillDone = 1'b0;
    AllocReq = 1'b1;
    tick();
    AllocReq = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (vv_b !== 1'b0 || victim_b !== 3'b000 || lfsr_b !== 4'b0010) begin
      miscompares++;
      $display("FAIL np2_reset_hold: valid %b victim %b lfsr %b want 0/000/0010",
               vv_b, victim_b, lfsr_b);
    end
  endtask

`ifdef RANDREPL_SEED_EN
  task automatic test_seed();
    apply_reset();
    valid_a   = 4'b1111;
    SeedData  = 4'b0110;
    SeedWrite = 1'b1;
    tick();
    SeedWrite = 1'b0;
    vectors++;
    if (lfsr_a !== 4'b0110 || vv_a !== 1'b0) begin
      miscompares++;
      $display("FAIL seed_load: lfsr %b valid %b want 0110/0", lfsr_a, vv_a);
    end
    SeedData  = 4'b0000;
    SeedWrite = 1'b1;
    tick();
    SeedWrite = 1'b0;
    vectors++;
    if (lfsr_a !== 4'b0010) begin
      miscompares++;
      $display("FAIL seed_zero: lfsr %b want 0010", lfsr_a);
    end
    AllocReq = 1'b1;
    tick();
    AllocReq = 1'b0;
    SeedData  = 4'b1011;
    SeedWrite = 1'b1;
    FillDone  = 1'b1;
    tick();
    SeedWrite = 1'b0;
    FillDone  = 1'b0;
    vectors++;
    if (lfsr_a !== 4'b1011 || vv_a !== 1'b0) begin
      miscompares++;
      $display("FAIL seed_vs_fill: lfsr %b valid %b want 1011/0", lfsr_a, vv_a);
    end
  endtask
`endif

  initial begin
    reset      = 1'b1;
    FlushStage = 1'b0;
    AllocReq   = 1'b0;
    FillDone   = 1'b0;
    valid_a    = 4'b1111;
    valid_b    = 3'b111;
`ifdef RANDREPL_SEED_EN
    SeedWrite  = 1'b0;
    SeedData   = 4'b0000;
`endif
    test_reset();
    test_random_alloc();
    test_invalid_priority();
    test_flush();
    test_back_to_back();
    test_nonpow2();
`ifdef RANDREPL_SEED_EN
    test_seed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
